stats_sequencer: RTL and testbench
==================================

// Module: stats_sequencer
// PURPOSE
//  Hardwired sequencer computing MAX, MIN and integer average (QUOTIENT/REMAINDER) over a block of
//  COUNT bytes in the shared data memory. Walks addresses BASE_ADDR..BASE_ADDR+COUNT-1 at one read
//  per cycle, then divides the sum by COUNT through repeated subtraction.
//  Offloads the MAX/MIN/AVG kernel from the microcoded control unit. Owns the memory read port while BUSY.
// PARAMETERS
//  DATA_W  8   memory word and MAX/MIN/QUOTIENT/REMAINDER width
//  ADDR_W  8   memory address width; address arithmetic wraps modulo 2**ADDR_W
//  CNT_W   8   element count width; internal sum is DATA_W+CNT_W bits and never overflows
// PORTS
//  CLK        in   1       single clock, all state on rising edge
//  RESET      in   1       synchronous, active-high
//  START      in   1       request; accepted only in IDLE
//  BASE_ADDR  in   ADDR_W  first element address, sampled on accept
//  COUNT      in   CNT_W   number of elements, sampled on accept
//  MEM_ADDR   out  ADDR_W  read address to memory
//  MEM_RD_EN  out  1       read strobe; memory returns MEM_RDATA one cycle later
//  MEM_RDATA  in   DATA_W  registered memory read data
//  BUSY       out  1       high from cycle after accept until DONE cycle inclusive
//  DONE       out  1       one-cycle pulse; results valid from this cycle
//  ERR        out  1       set with DONE when COUNT==0; cleared on next accept
//  MAX        out  DATA_W  unsigned maximum, held until next DONE
//  MIN        out  DATA_W  unsigned minimum, held until next DONE
//  QUOTIENT   out  DATA_W  floor(sum/COUNT)
//  REMAINDER  out  DATA_W  sum mod COUNT
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (MEM_ADDR 0, MEM_RD_EN 0, BUSY 0, DONE 0, ERR 0, results 0).
//  States: IDLE, READ, LAST, DIV, DONE.
//  IDLE: START=1 at cycle 0 -> latch BASE_ADDR/COUNT, clear ERR; COUNT==0 -> DONE, else -> READ.
//  READ (cycles 1..N): MEM_RD_EN=1, MEM_ADDR=BASE_ADDR+(k-1) wrapped; from cycle 2 capture previous
//    word: max/min compare (first word loads both), sum+=word. After Nth issue -> LAST.
//  LAST (cycle N+1): MEM_RD_EN=0, capture final word; rem<=sum, q<=0 -> DIV.
//  DIV: each cycle, if rem>=COUNT {rem-=COUNT; q++} else -> DONE. Takes Q+1 cycles.
//  DONE (cycle N+Q+3): results registered on the edge entering DONE; DONE=1, BUSY=1; next -> IDLE.
//  COUNT==0: DONE at cycle 1, ERR=1, MAX=MIN=QUOTIENT=REMAINDER=0, no memory reads.
//  COUNT==1: single read; MAX=MIN=word, QUOTIENT=word, REMAINDER=0.
//  START while not IDLE: ignored, no effect. START in DONE cycle: ignored (accepted next cycle).
//  MEM_RD_EN low in all states except READ; MEM_ADDR holds last value when not reading.
//  RESET mid-operation: immediate return to IDLE, all outputs to reset values, partial results discarded.
//  Result outputs never change except at DONE or RESET.
// CONFIGURATION
//  STATS_ABORT_EN defined: extra input ABORT (1 bit). ABORT=1 in READ/LAST/DIV -> next cycle DONE
//    with ERR=1 and result outputs unchanged (previous values retained); ABORT in IDLE/DONE ignored.
//  STATS_ABORT_EN undefined: no ABORT port; operation always runs to completion.
// TESTING
//  Mem[10..13]=5,7,3,9; START, BASE=10, COUNT=4 -> DONE at cycle 13, MAX=9 MIN=3 QUOT=6 REM=0 ERR=0.
//  Mem[20..22]=1,2,2; COUNT=3 -> MAX=2 MIN=1 QUOT=1 REM=2; MEM_RD_EN high exactly cycles 1..3.
//  BASE=0xFE, COUNT=3, mem FE/FF/00=255,255,254 -> addresses FE,FF,00; MAX=255 MIN=254 QUOT=254 REM=2.
//  COUNT=0 -> DONE at cycle 1, ERR=1, all results 0, MEM_RD_EN never asserted.
//  START pulsed at cycle 3 of a COUNT=4 run -> ignored, first run results unchanged, BUSY continuous.
//  RESET asserted at cycle 3 of a run -> next cycle BUSY=0, outputs 0; STATS_ABORT_EN: ABORT at cycle 2 -> DONE, ERR=1, results kept.

Source files
------------

// File: rtl/stats_sequencer.sv
// stats_sequencer: hardwired MAX / MIN / integer-average kernel over a block of bytes in the
// shared data memory. Reads base_addr..base_addr+count-1, one read per cycle, then divides the
// running sum by count through repeated subtraction. Owns the memory read port while busy.
//
// Optional feature: define STATS_ABORT_EN to add the abort input. An abort in READ/LAST/DIV
// ends the run on the next cycle with err set and the previous results retained.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   reset      synchronous, active-high
//   start      request, accepted only in IDLE
//   base_addr  first element address, sampled on accept
//   count      number of elements, sampled on accept
//   mem_addr   read address to memory (holds its last value when not reading)
//   mem_rd_en  read strobe; mem_rdata returns one cycle later
//   mem_rdata  registered memory read data
//   busy       high from the cycle after accept through the done cycle
//   done       one-cycle pulse; results valid from this cycle
//   err        set with done when count==0 (or on abort); cleared on the next accept
//   max/min    unsigned maximum / minimum, held until the next done
//   quotient   floor(sum / count)
//   remainder  sum mod count
//   abort      (STATS_ABORT_EN only) cancel the run in progress
module stats_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
`ifdef STATS_ABORT_EN
  input  logic              abort,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] max,
  output logic [DATA_W-1:0] min,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  // Sum of up to 2**CNT_W-1 words of DATA_W bits cannot overflow this width.
  localparam int unsigned SUM_W = DATA_W + CNT_W;

  typedef enum logic [2:0] {StIdle, StRead, StLast, StDiv, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    remaining_q;
  logic                cap_q;        // mem_rdata holds a word requested last cycle
  logic                seen_q;       // at least one word folded into max/min
  logic [DATA_W-1:0]   wmax_q, wmin_q;
  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    rem_q;
  logic [DATA_W-1:0]   quo_q;
  logic [DATA_W-1:0]   max_q, min_q, quo_out_q, rem_out_q;
  logic                err_q;

  logic                accept;
  logic                finish;
  logic                abort_hit;
  logic [SUM_W-1:0]    word_ext;
  logic [SUM_W-1:0]    cnt_ext;
  logic                rem_ge;

  assign word_ext = SUM_W'(mem_rdata);
  assign cnt_ext  = SUM_W'(cnt_q);
  assign rem_ge   = (rem_q >= cnt_ext);

`ifdef STATS_ABORT_EN
  assign abort_hit = abort && (state_q inside {StRead, StLast, StDiv});
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (count == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        if (remaining_q == CNT_W'(1)) state_d = StLast;
      end
      StLast: state_d = StDiv;
      StDiv: begin
        if (!rem_ge) begin
          finish  = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort pre-empts normal completion; results are not committed.
    if (abort_hit) begin
      finish  = 1'b0;
      state_d = StDone;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cnt_q       <= '0;
      remaining_q <= '0;
      cap_q       <= 1'b0;
      seen_q      <= 1'b0;
      wmax_q      <= '0;
      wmin_q      <= '0;
      sum_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      max_q       <= '0;
      min_q       <= '0;
      quo_out_q   <= '0;
      rem_out_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= (state_q == StRead);

      if (accept) begin
        cnt_q       <= count;
        remaining_q <= count;
        sum_q       <= '0;
        seen_q      <= 1'b0;
        err_q       <= (count == '0);
        if (count == '0) begin
          max_q     <= '0;
          min_q     <= '0;
          quo_out_q <= '0;
          rem_out_q <= '0;
        end else begin
          addr_q <= base_addr;
        end
      end

      // Address advances after every issue except the last, so it holds the final address.
      if (state_q == StRead) begin
        remaining_q <= remaining_q - CNT_W'(1);
        if (remaining_q != CNT_W'(1)) addr_q <= addr_q + ADDR_W'(1);
      end

      if (cap_q) begin
        sum_q  <= sum_q + word_ext;
        seen_q <= 1'b1;
        if (!seen_q || mem_rdata > wmax_q) wmax_q <= mem_rdata;
        if (!seen_q || mem_rdata < wmin_q) wmin_q <= mem_rdata;
      end

      // Final word arrives in LAST; fold it straight into the dividend.
      if (state_q == StLast) begin
        rem_q <= sum_q + word_ext;
        quo_q <= '0;
      end

      if (state_q == StDiv && rem_ge) begin
        rem_q <= rem_q - cnt_ext;
        quo_q <= quo_q + DATA_W'(1);
      end

      if (finish) begin
        max_q     <= wmax_q;
        min_q     <= wmin_q;
        quo_out_q <= quo_q;
        rem_out_q <= rem_q[DATA_W-1:0];
      end

      if (abort_hit) err_q <= 1'b1;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd_en = (state_q == StRead);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign max       = max_q;
  assign min       = min_q;
  assign quotient  = quo_out_q;
  assign remainder = rem_out_q;

endmodule

// File: tb/tb_stats_sequencer.sv
// Bench for stats_sequencer: directed cases plus randomized runs checked against a
// behavioural model (plain arithmetic over the bench's memory array).
module tb_stats_sequencer;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] base_addr, count, mem_addr, mem_rdata;
  logic       mem_rd_en, busy, done, err;
  logic [7:0] max, min, quotient, remainder;
`ifdef STATS_ABORT_EN
  logic       abort = 1'b0;
`endif

  always #5 clk = ~clk;

  stats_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
`ifdef STATS_ABORT_EN
    .abort     (abort),
`endif
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .max       (max),
    .min       (min),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Registered-read memory.
  logic [7:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int errors = 0;
  int checks = 0;

  // Expected results of the most recent completed run.
  logic [7:0] m_max = 0, m_min = 0, m_quo = 0, m_rem = 0;
  logic       m_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [7:0] b, input logic [7:0] n, output int ecyc);
    int sum;
    logic [7:0] a, w;
    sum = 0;
    m_max = 0;
    m_min = 0;
    for (int i = 0; i < int'(n); i++) begin
      a = b + 8'(i);
      w = mem[a];
      if (i == 0 || w > m_max) m_max = w;
      if (i == 0 || w < m_min) m_min = w;
      sum += int'(w);
    end
    if (n == 0) begin
      m_quo = 0;
      m_rem = 0;
      m_err = 1;
      ecyc  = 1;
    end else begin
      m_quo = 8'(sum / int'(n));
      m_rem = 8'(sum % int'(n));
      m_err = 0;
      ecyc  = int'(n) + sum / int'(n) + 3;
    end
  endtask

  // One full run; optionally pulses start again at cycle pulse_at.
  task automatic run(input string tag, input logic [7:0] b, input logic [7:0] n,
                     input int pulse_at);
    int ecyc, cyc, busy_bad, rd_cnt, rd_bad;
    model(b, n, ecyc);
    @(negedge clk);
    base_addr = b;
    count     = n;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = 8'($urandom);
    count     = 8'($urandom);
    cyc = -1; busy_bad = 0; rd_cnt = 0; rd_bad = 0;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (!busy) busy_bad++;
      if (mem_rd_en) begin
        rd_cnt++;
        if (c > int'(n) || mem_addr !== 8'(int'(b) + c - 1)) rd_bad++;
      end
      start = (c == pulse_at);
      if (done) begin
        cyc = c;
        break;
      end
    end
    start = 1'b0;
    check({tag, ".done_cycle"}, cyc, ecyc);
    check({tag, ".err"}, err, m_err);
    check({tag, ".max"}, max, m_max);
    check({tag, ".min"}, min, m_min);
    check({tag, ".quot"}, quotient, m_quo);
    check({tag, ".rem"}, remainder, m_rem);
    check({tag, ".busy_gaps"}, busy_bad, 0);
    check({tag, ".rd_count"}, rd_cnt, n);
    check({tag, ".rd_addr"}, rd_bad, 0);
    repeat (3) @(negedge clk);
    check({tag, ".idle_busy"}, {done, busy, mem_rd_en}, 3'b000);
    check({tag, ".hold_max"}, max, m_max);
    check({tag, ".hold_quot_rem"}, {quotient, remainder, err}, {m_quo, m_rem, m_err});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = 0; count = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[10] = 5; mem[11] = 7; mem[12] = 3; mem[13] = 9;
    mem[20] = 1; mem[21] = 2; mem[22] = 2;
    mem[8'hFE] = 255; mem[8'hFF] = 255; mem[8'h00] = 254;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.ctrl", {busy, done, err, mem_rd_en}, 4'b0000);
    check("reset.addr", mem_addr, 0);
    check("reset.results", {max, min, quotient, remainder}, 32'h0);
    reset = 1'b0;

    run("avg4", 8'd10, 8'd4, 0);
    run("avg3", 8'd20, 8'd3, 0);
    run("wrap", 8'hFE, 8'd3, 0);
    run("cnt0", 8'd40, 8'd0, 0);
    run("cnt1", 8'd21, 8'd1, 0);
    run("restart", 8'd10, 8'd4, 3);

`ifdef STATS_ABORT_EN
    @(negedge clk);
    base_addr = 10; count = 4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort.done", {done, busy, err}, 3'b111);
    check("abort.kept", {max, min, quotient, remainder}, {m_max, m_min, m_quo, m_rem});
    repeat (2) @(negedge clk);
`endif

    for (int r = 0; r < 16; r++) run("rand", 8'($urandom), 8'($urandom_range(1, 40)), 0);
    run("rand_full", 8'($urandom), 8'd255, 0);

    // Reset mid-run discards everything.
    @(negedge clk);
    base_addr = 10; count = 4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset.ctrl", {busy, done, err, mem_rd_en}, 4'b0000);
    check("midreset.addr", mem_addr, 0);
    check("midreset.results", {max, min, quotient, remainder}, 32'h0);
    reset = 1'b0;
    run("after_reset", 8'd20, 8'd3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
